// File: rtl/wshb_pixel_sink_pkg.sv
// Shared constants, pixel payload type and status-word layout for the pixel sink.
package wshb_pix_pkg;

  localparam int unsigned HDISP_DEF = 800;
  localparam int unsigned VDISP_DEF = 480;
  localparam int unsigned X_W       = $clog2(HDISP_DEF);
  localparam int unsigned Y_W       = $clog2(VDISP_DEF);
  localparam int unsigned RGB_W     = 24;

  // Status word: {seq_err, 7'b0, frame_cnt[7:0], 11'b0, count[4:0]}
  localparam int unsigned ST_COUNT_LSB   = 0;
  localparam int unsigned ST_COUNT_W     = 5;
  localparam int unsigned ST_FRAME_LSB   = 16;
  localparam int unsigned ST_FRAME_W     = 8;
  localparam int unsigned ST_SEQ_ERR_BIT = 31;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [RGB_W-1:0] rgb;
  } pixel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TERM = 1'b1
  } term_state_e;

endpackage

// File: rtl/wshb_pixel_sink_if.sv
// Wishbone classic bus plus outgoing pixel stream of the pixel sink.
interface wshb_pixel_sink_if;
  import wshb_pix_pkg::*;

  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic [31:0]      wb_adr;
  logic [3:0]       wb_sel;
  logic [31:0]      wb_dat_ms;
  logic [31:0]      wb_dat_sm;
  logic             wb_ack;
  logic             wb_err;
  logic             pix_valid;
  logic             pix_ready;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic [RGB_W-1:0] pix_rgb;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms, pix_ready,
    input  wb_dat_sm, wb_ack, wb_err, pix_valid, pix_x, pix_y, pix_rgb
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms, pix_ready,
    output wb_dat_sm, wb_ack, wb_err, pix_valid, pix_x, pix_y, pix_rgb
  );

endinterface

// File: rtl/wshb_pixel_sink_fifo.sv
// Synchronous FIFO with registered storage and occupancy count; head read straight from storage.
module pix_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter type         T     = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push_c;
  logic             do_pop_c;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign do_push_c = push & ~full;
  assign do_pop_c  = pop & ~empty;
  assign dout      = mem[rd_ptr_q];
  assign count     = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr_q] <= din;
        wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wshb_pixel_sink.sv
// Wishbone classic slave that turns framebuffer writes into an {x, y, rgb} pixel stream,
// checks raster order and counts completed frames.
module wshb_pixel_sink
  import wshb_pix_pkg::*;
#(
  parameter int unsigned HDISP      = HDISP_DEF,
  parameter int unsigned VDISP      = VDISP_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  wshb_pixel_sink_if.slave   bus,
  output logic               frame_done,
  output logic               seq_err
);

  localparam int unsigned NPIX  = HDISP * VDISP;
  localparam int unsigned IDX_W = 30;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [IDX_W-1:0]      idx_c;
  logic [IDX_W-1:0]      exp_idx_q;
  logic [X_W-1:0]        x_c;
  logic [Y_W-1:0]        y_c;
  logic                  in_range_c, sel_ok_c, last_c;
  logic                  req_c, wr_ok_c, wr_bad_c, rd_c;
  term_state_e           state_q, state_d;
  logic                  ack_q, err_q, push_q;
  pixel_t                push_pix_q, head_c;
  logic [31:0]           dat_q, status_c;
  logic [ST_FRAME_W-1:0] frame_cnt_q;
  logic                  fifo_full, fifo_empty, pop_c;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [ST_COUNT_W-1:0] cnt_sat_c;
  logic                  unused_c;

  // Address decode: word index into raster coordinates.
  assign idx_c      = bus.wb_adr[31:2];
  assign in_range_c = 32'(idx_c) < NPIX;
  assign sel_ok_c   = (bus.wb_sel == 4'hF);
  assign last_c     = 32'(idx_c) == (NPIX - 1);
  assign x_c        = X_W'(idx_c % IDX_W'(HDISP));
  assign y_c        = Y_W'(idx_c / IDX_W'(HDISP));
  assign unused_c   = ^{bus.wb_adr[1:0], bus.wb_dat_ms[31:RGB_W]};

  assign req_c    = bus.wb_cyc & bus.wb_stb & ~ack_q & ~err_q & (state_q == ST_IDLE);
  assign wr_ok_c  = req_c & bus.wb_we & in_range_c & sel_ok_c & ~fifo_full;
  assign wr_bad_c = req_c & bus.wb_we & ~(in_range_c & sel_ok_c);
  assign rd_c     = req_c & ~bus.wb_we;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wr_ok_c | wr_bad_c | rd_c) state_d = ST_TERM;
      ST_TERM: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    cnt_sat_c = (32'(fifo_cnt) > 32'd31) ? ST_COUNT_W'(31) : ST_COUNT_W'(fifo_cnt);
    status_c = '0;
    status_c[ST_SEQ_ERR_BIT]                 = seq_err;
    status_c[ST_FRAME_LSB +: ST_FRAME_W]     = frame_cnt_q;
    status_c[ST_COUNT_LSB +: ST_COUNT_W]     = cnt_sat_c;
  end

  // Termination and push payload; the push lands on the edge that ends the ack cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      push_q     <= 1'b0;
      push_pix_q <= '0;
      dat_q      <= '0;
    end else begin
      ack_q  <= wr_ok_c | rd_c;
      err_q  <= wr_bad_c;
      push_q <= wr_ok_c;
      if (wr_ok_c) push_pix_q <= '{x: x_c, y: y_c, rgb: bus.wb_dat_ms[RGB_W-1:0]};
      if (rd_c)    dat_q      <= status_c;
    end
  end

  // Raster-order checker resynchronises on the actual address; frame counter wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_idx_q   <= '0;
      seq_err     <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      frame_done <= 1'b0;
      if (wr_ok_c) begin
        if (idx_c != exp_idx_q) seq_err <= 1'b1;
        exp_idx_q  <= last_c ? '0 : idx_c + IDX_W'(1);
        frame_done <= last_c;
        if (last_c) frame_cnt_q <= frame_cnt_q + ST_FRAME_W'(1);
      end
    end
  end

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pixel_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (push_pix_q),
    .pop   (pop_c),
    .dout  (head_c),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign pop_c         = ~fifo_empty & bus.pix_ready;
  assign bus.pix_valid = ~fifo_empty;
  assign bus.pix_x     = head_c.x;
  assign bus.pix_y     = head_c.y;
  assign bus.pix_rgb   = head_c.rgb;
  assign bus.wb_ack    = ack_q;
  assign bus.wb_err    = err_q;
  assign bus.wb_dat_sm = dat_q;

endmodule

// File: tb/tb_wshb_pixel_sink.sv
// Scoreboard bench for wshb_pixel_sink: driver queues expected terminations and pixels,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_wshb_pixel_sink;
  import wshb_pix_pkg::*;

  typedef struct packed {
    logic        err;
    logic        rd;
    logic [31:0] dat;
  } term_t;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_done;
  logic seq_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  term_t  term_q[$];
  pixel_t pix_q[$];

  wshb_pixel_sink_if bus ();

  wshb_pixel_sink u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .frame_done (frame_done),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic pixel_t mkpix(input int unsigned idx);
    pixel_t p;
    p.x   = X_W'(idx % 800);
    p.y   = Y_W'(idx / 800);
    p.rgb = 24'(idx);
    return p;
  endfunction

  // Monitor: every termination and every accepted pixel must match the head of its queue.
  always @(negedge clk) begin
    term_t  t;
    pixel_t p;
    if (rst_n === 1'b1) begin
      if (bus.wb_ack || bus.wb_err) begin
        if (term_q.size() == 0) chk("unexpected_term", 64'(bus.wb_ack | bus.wb_err), 64'd0);
        else begin
          t = term_q.pop_front();
          chk("term_err", 64'(bus.wb_err), 64'(t.err));
          if (t.rd) chk("rd_dat", 64'(bus.wb_dat_sm), 64'(t.dat));
        end
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (pix_q.size() == 0) chk("unexpected_pix", 64'(bus.pix_valid), 64'd0);
        else begin
          p = pix_q.pop_front();
          chk("pix", 64'({bus.pix_x, bus.pix_y, bus.pix_rgb}), 64'(p));
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
    bus.wb_cyc    = 1'b1;
    bus.wb_stb    = 1'b1;
    bus.wb_we     = we;
    bus.wb_adr    = adr;
    bus.wb_sel    = sel;
    bus.wb_dat_ms = dat;
  endtask

  task automatic wb_drop();
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
  endtask

  task automatic wb_wait(input int maxc, output bit got);
    got = 1'b0;
    for (int c = 0; c < maxc && !got; c++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack || bus.wb_err) got = 1'b1;
    end
    if (got) wb_drop();
  endtask

  task automatic wr(input int unsigned idx, input logic [3:0] sel, input bit exp_err);
    bit got;
    term_q.push_back('{err: exp_err, rd: 1'b0, dat: 32'h0});
    if (!exp_err) pix_q.push_back(mkpix(idx));
    wb_start(1'b1, 32'(idx) << 2, sel, {8'hA5, 24'(idx)});
    wb_wait(20, got);
    chk("wr_term", 64'(got), 64'd1);
    if (!got) wb_drop();
  endtask

  task automatic rd(input logic [31:0] exp);
    bit got;
    term_q.push_back('{err: 1'b0, rd: 1'b1, dat: exp});
    wb_start(1'b0, 32'h0000_1234, 4'h0, 32'h0);
    wb_wait(20, got);
    chk("rd_term", 64'(got), 64'd1);
    if (!got) wb_drop();
  endtask

  task automatic do_reset();
    wb_drop();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    term_q.delete();
    pix_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    int fd_base;
    rst_n         = 1'b0;
    bus.wb_cyc    = 1'b0;
    bus.wb_stb    = 1'b0;
    bus.wb_we     = 1'b0;
    bus.wb_adr    = '0;
    bus.wb_sel    = '0;
    bus.wb_dat_ms = '0;
    bus.pix_ready = 1'b1;
    idle(3);

    // Reset state
    chk("rst_ack",     64'(bus.wb_ack),    64'd0);
    chk("rst_err",     64'(bus.wb_err),    64'd0);
    chk("rst_dat",     64'(bus.wb_dat_sm), 64'd0);
    chk("rst_valid",   64'(bus.pix_valid), 64'd0);
    chk("rst_pix",     64'({bus.pix_x, bus.pix_y, bus.pix_rgb}), 64'd0);
    chk("rst_fdone",   64'(frame_done),    64'd0);
    chk("rst_seq_err", 64'(seq_err),       64'd0);
    rst_n = 1'b1;

    // Raster stream prefix with the 1-cycle ack-to-stream latency check on pixel 801
    for (int unsigned i = 0; i <= 1000; i++) begin
      wr(i, 4'hF, 1'b0);
      if (i == 801) begin
        idle(1);
        chk("p801_valid", 64'(bus.pix_valid), 64'd1);
        chk("p801_xy",    64'({bus.pix_x, bus.pix_y}), 64'({10'd1, 9'd1}));
      end
    end
    idle(5);
    chk("raster_seq_err", 64'(seq_err), 64'd0);
    rd(32'h0000_0000);

    // Frame boundary: last pixel pulses frame_done, counter wraps exp_idx
    do_reset();
    fd_base = fd_cnt;
    wr(383998, 4'hF, 1'b0);
    wr(383999, 4'hF, 1'b0);
    chk("fdone_on_ack", 64'(frame_done), 64'd1);
    wr(0, 4'hF, 1'b0);
    chk("fdone_low", 64'(frame_done), 64'd0);
    idle(4);
    chk("fdone_count", 64'(fd_cnt - fd_base), 64'd1);
    rd(32'h8001_0000);

    // Errors: out-of-range index and partial byte select
    do_reset();
    wr(0, 4'hF, 1'b0);
    wr(384000, 4'hF, 1'b1);
    wr(1, 4'h7, 1'b1);
    wr(1, 4'hF, 1'b0);
    chk("err_seq_err", 64'(seq_err), 64'd0);
    idle(4);
    rd(32'h0000_0000);

    // Order check
    do_reset();
    wr(0, 4'hF, 1'b0);
    wr(1, 4'hF, 1'b0);
    chk("ord_1", 64'(seq_err), 64'd0);
    wr(5, 4'hF, 1'b0);
    chk("ord_5", 64'(seq_err), 64'd1);
    wr(6, 4'hF, 1'b0);
    chk("ord_6", 64'(seq_err), 64'd1);
    idle(4);

    // Backpressure: 16 accepted, 17th stalls until the consumer drains
    do_reset();
    bus.pix_ready = 1'b0;
    for (int unsigned i = 0; i < 16; i++) wr(i, 4'hF, 1'b0);
    term_q.push_back('{err: 1'b0, rd: 1'b0, dat: 32'h0});
    pix_q.push_back(mkpix(16));
    wb_start(1'b1, 32'd16 << 2, 4'hF, 32'd16);
    wb_wait(10, got);
    chk("stall_no_ack", 64'(got), 64'd0);
    bus.pix_ready = 1'b1;
    wb_wait(20, got);
    chk("stall_resume", 64'(got), 64'd1);
    if (!got) wb_drop();
    for (int unsigned i = 17; i < 20; i++) wr(i, 4'hF, 1'b0);
    idle(30);
    chk("bp_drained", 64'(pix_q.size()), 64'd0);

    // Status read with three buffered pixels
    do_reset();
    bus.pix_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) wr(i, 4'hF, 1'b0);
    rd(32'h0000_0003);
    bus.pix_ready = 1'b1;
    idle(10);

    // Reset mid-operation with 5 entries held and a request pending
    do_reset();
    bus.pix_ready = 1'b0;
    wr(0, 4'hF, 1'b0);
    wr(1, 4'hF, 1'b0);
    wr(2, 4'hF, 1'b0);
    wr(3, 4'hF, 1'b0);
    wr(7, 4'hF, 1'b0);
    chk("pre_rst_seq_err", 64'(seq_err), 64'd1);
    idle(1);
    wb_start(1'b1, 32'd8 << 2, 4'hF, 32'd8);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid",   64'(bus.pix_valid), 64'd0);
    chk("mid_rst_ack",     64'(bus.wb_ack),    64'd0);
    chk("mid_rst_seq_err", 64'(seq_err),       64'd0);
    wb_drop();
    rst_n = 1'b1;
    term_q.delete();
    pix_q.delete();
    idle(2);
    chk("post_rst_valid", 64'(bus.pix_valid), 64'd0);
    rd(32'h0000_0000);
    bus.pix_ready = 1'b1;
    idle(4);

    chk("term_q_empty", 64'(term_q.size()), 64'd0);
    chk("pix_q_empty",  64'(pix_q.size()),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wshb_pixel_sink.md
# wshb_pixel_sink

Wishbone classic slave that terminates the framebuffer write traffic produced by the pattern/pixel masters of the SoC. It decodes each accepted 32-bit byte-addressed write into raster coordinates, buffers `{x, y, rgb}` in a small FIFO and presents it on a valid/ready pixel stream toward the video/compare logic. It also checks raster ordering and flags frame completion, so it serves both as a simulation responder and as an on-chip monitor.

## Interface
- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of two, ≥ 2)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `wb_cyc`  in  1  bus cycle
- `wb_stb`  in  1  strobe
- `wb_we`  in  1  write enable
- `wb_adr`  in  32  byte address
- `wb_sel`  in  4  byte selects
- `wb_dat_ms`  in  32  write data, `[23:0]` = RGB
- `wb_dat_sm`  out  32  read data (status word)
- `wb_ack`  out  1  normal termination
- `wb_err`  out  1  error termination
- `pix_valid`  out  1  FIFO head valid
- `pix_ready`  in  1  consumer accepts head
- `pix_x`  out  $clog2(HDISP)  head x
- `pix_y`  out  $clog2(VDISP)  head y
- `pix_rgb`  out  24  head colour
- `frame_done`  out  1  one-cycle pulse, last pixel of frame accepted
- `seq_err`  out  1  sticky raster-order error

## Operation
- Request `req = wb_cyc & wb_stb & ~wb_ack & ~wb_err`.
- Pixel index `idx = wb_adr[31:2]`; `wb_adr[1:0]` ignored. `x = idx % HDISP`, `y = idx / HDISP`, computed combinationally from `idx`. Widths are fixed by `$clog2`.
- **Write accept**: `req & wb_we & idx < HDISP*VDISP & wb_sel == 4'hF & ~full`. The block pushes `{x, y, wb_dat_ms[23:0]}` and asserts `wb_ack`.
- **Write error**: `req & wb_we` with `idx` out of range or `wb_sel != 4'hF`. The block asserts `wb_err`, pushes nothing, and leaves the sequence state unchanged.
- **Write stall**: `req & wb_we & full` and otherwise legal. No termination is issued; the request stays pending until the FIFO has room.
- **Read**: `req & ~wb_we` asserts `wb_ack` regardless of address. `wb_dat_sm = {seq_err, 7'b0, frame_cnt[7:0], 11'b0, count[4:0]}`, registered with the ack. `count` saturates its 5-bit field display at 31.
- **Sequence checker**: `exp_idx` is reset to 0. On each write accept:
  - if `idx != exp_idx`, set `seq_err`;
  - then `exp_idx <= (idx == HDISP*VDISP-1) ? 0 : idx+1`, so the checker resynchronises on the actual address.
- **Frame done**: `frame_done` pulses in the ack cycle of an accepted write with `idx == HDISP*VDISP-1`. `frame_cnt` (8 bit, wraps) increments in the same cycle.
- **FIFO**: pop on `pix_valid & pix_ready`. `full`/`empty` derive from the registered count.
  - Push and pop in the same cycle leave the count unchanged.
  - Push is blocked while the count equals `FIFO_DEPTH`, even if a pop happens that cycle.
- `seq_err` clears only on reset.

## Timing
- `wb_ack`/`wb_err` are registered: asserted the cycle after `req` is sampled true with its condition met, held exactly 1 cycle, then forced low for at least 1 cycle.
- Peak throughput is one transfer per 2 cycles, whether the master holds `stb` high continuously or not.
- Push takes effect on the ack edge. `pix_valid` rises 1 cycle after `wb_ack` rises when the FIFO was empty, so ack-to-stream latency is 1 cycle.
- FIFO outputs come from registered storage; there is no bypass.
- Reset values: `wb_ack=0`, `wb_err=0`, `wb_dat_sm=0`, `pix_valid=0`, `pix_x/pix_y/pix_rgb=0`, `frame_done=0`, `seq_err=0`, FIFO empty, `exp_idx=0`, `frame_cnt=0`.
- Reset mid-transaction drops any pending termination and flushes the FIFO. The master must restart the cycle.
- `wb_cyc` deasserted while a request is pending means no termination is issued.

## Structure
- Package `wshb_pix_pkg` holds:
  - `pixel_t` struct `{x, y, rgb}`, with widths derived from the package constants `HDISP_DEF = 800` and `VDISP_DEF = 480`;
  - the status-word field offsets.
- Sub-module `pix_fifo`: synchronous FIFO parameterised by `FIFO_DEPTH` and the element type. It provides `push`, `pop`, `full`, `empty`, `count` and head data, with active-low synchronous reset.
- The top level contains the decode, Wishbone termination FSM (IDLE → TERM → IDLE), sequence checker and counters.

## Test plan
- **Raster stream**: consumer with `pix_ready=1`; master writes `adr = 4*i` for `i = 0..383999` with `rgb = i[23:0]`.
  - Required: one ack per write, `frame_done` pulses exactly once at `i = 383999`, `seq_err = 0`.
  - Pixel `i = 801` appears as `x = 1, y = 1`.
- **Backpressure**: `pix_ready=0`, 20 legal writes.
  - Required: 16 acks, then `stb` stays pending with no ack.
  - Raising `pix_ready` resumes acks. All 20 pixels come out in order.
- **Errors**:
  - write at `adr = 4*384000` gives `wb_err`, no push, `exp_idx` unchanged;
  - write with `sel = 4'b0111` gives `wb_err`.
- **Order check**: write indices 0, 1, 5, 6. Required: `seq_err` rises on the ack of index 5, stays high, and the ack for index 6 still arrives.
- **Status read**: after 3 buffered writes, a read with `pix_ready=0` returns `count = 3` in `wb_dat_sm[4:0]` with `wb_ack`.
- **Reset mid-operation**: `rst_n` low for 1 cycle while the FIFO holds 5 entries and a request is pending.
  - Required: `pix_valid=0`, no ack, `seq_err=0`, `frame_cnt=0` the next cycle.
